// File: rtl/error_conv_check_if.sv
// error_conv_check_if: bus between the absolute-error/W delivery stage and the
// convergence checker.
//
// Handshake: en_conv is a one-cycle start pulse that is accepted only while
// o_busy=0 and o_done=0 (IDLE); the block then owns its captured copy and
// answers 17 cycles later with either a one-cycle o_next_iter pulse or a
// level o_done (qualified by o_converged). There is no backpressure.
//
// Array index k maps to element (row, col) row-major: k = 4*(row-1)+(col-1),
// so i_err[0]=i11, i_err[6]=i23, i_err[11]=i34, i_err[15]=i44 (same for
// iw_new/ow).
// Optional: ERR_SUM_EN adds o_err_sum.
interface error_conv_check_if #(
  parameter int DW = 26
);
  logic          en_conv;
  logic          i_restart;
  logic [DW-1:0] i_err  [16];
  logic [DW-1:0] iw_new [16];
  logic [DW-1:0] ow     [16];
  logic          o_busy;
  logic          o_next_iter;
  logic          o_done;
  logic          o_converged;
  logic [7:0]    o_iter_cnt;
  logic [DW-1:0] o_max_err;
`ifdef ERR_SUM_EN
  logic [DW+3:0] o_err_sum;
`endif
  logic [1:0]    o_dbg_state;

  modport master (
    output en_conv, i_restart, i_err, iw_new,
    input  ow, o_busy, o_next_iter, o_done, o_converged, o_iter_cnt, o_max_err,
`ifdef ERR_SUM_EN
    input  o_err_sum,
`endif
    input  o_dbg_state
  );

  modport slave (
    input  en_conv, i_restart, i_err, iw_new,
    output ow, o_busy, o_next_iter, o_done, o_converged, o_iter_cnt, o_max_err,
`ifdef ERR_SUM_EN
    output o_err_sum,
`endif
    output o_dbg_state
  );
endinterface

// File: rtl/error_conv_check.sv
// error_conv_check: convergence test for the FastICA iteration loop.
// Captures 16 absolute errors (Q13, signed DW bits) and 16 candidate W words,
// scans the errors serially for the maximum (negative = upstream overflow,
// treated as saturated positive), then either requests another iteration or
// declares convergence / iteration-limit exhaustion and publishes W.
// Optional feature macro: ERR_SUM_EN (adds an error-sum accumulator, the
// o_err_sum output and the SUM_TOL parameter; convergence then also needs
// sum <= SUM_TOL).
module error_conv_check #(
  parameter int            DW       = 26,
  parameter logic [DW-1:0] TOL      = 26'd8,
  parameter int            MAX_ITER = 64
`ifdef ERR_SUM_EN
  ,
  parameter logic [DW+3:0] SUM_TOL  = 30'd64
`endif
) (
  input  logic              clk_conv,
  input  logic              rst_conv,
  error_conv_check_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DECIDE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Largest positive DW-bit value; stands in for any negative error.
  localparam logic [DW-1:0] SAT_VAL    = {1'b0, {(DW-1){1'b1}}};
  localparam logic [7:0]    MAX_ITER_C = 8'(MAX_ITER);

  state_t        state;
  state_t        state_nxt;

  logic [DW-1:0] cap_err [16];
  logic [DW-1:0] cap_w   [16];
  logic [DW-1:0] w_out   [16];
  logic [3:0]    idx;
  logic [DW-1:0] run_max;
  logic [DW-1:0] cur_err;
  logic [DW-1:0] cur_sat;

  logic [7:0]    iter_cnt;
  logic [7:0]    cnt_inc;
  logic [DW-1:0] max_err;
  logic          done_r;
  logic          conv_r;
  logic          next_r;
  logic          conv_hit;
  logic          limit_hit;
  logic          capture;

`ifdef ERR_SUM_EN
  logic [DW+3:0] run_sum;
  logic [DW+3:0] err_sum;
`endif

  // Element selection, saturation and the decision terms used in DECIDE.
  always_comb begin
    cur_err   = cap_err[idx];
    cur_sat   = cur_err[DW-1] ? SAT_VAL : cur_err;
    cnt_inc   = iter_cnt + 8'd1;
    capture   = (state == S_IDLE) && bus.en_conv;
`ifdef ERR_SUM_EN
    conv_hit  = (run_max <= TOL) && (run_sum <= SUM_TOL);
`else
    conv_hit  = (run_max <= TOL);
`endif
    limit_hit = (cnt_inc == MAX_ITER_C);
  end

  // State register.
  always_ff @(posedge clk_conv) begin
    if (rst_conv) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.en_conv) state_nxt = S_SCAN;
      S_SCAN:   if (idx == 4'd15) state_nxt = S_DECIDE;
      S_DECIDE: state_nxt = (conv_hit || limit_hit) ? S_DONE : S_IDLE;
      S_DONE:   if (bus.i_restart) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Capture registers: loaded only on an accepted start, untouched otherwise.
  always_ff @(posedge clk_conv) begin
    if (rst_conv) begin
      for (int i = 0; i < 16; i++) begin
        cap_err[i] <= '0;
        cap_w[i]   <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < 16; i++) begin
        cap_err[i] <= bus.i_err[i];
        cap_w[i]   <= bus.iw_new[i];
      end
    end
  end

  // Serial scan: one element per cycle, running maximum (and sum).
  always_ff @(posedge clk_conv) begin
    if (rst_conv) begin
      idx     <= '0;
      run_max <= '0;
`ifdef ERR_SUM_EN
      run_sum <= '0;
`endif
    end else if (capture) begin
      idx     <= '0;
      run_max <= '0;
`ifdef ERR_SUM_EN
      run_sum <= '0;
`endif
    end else if (state == S_SCAN) begin
      idx     <= idx + 4'd1;
      run_max <= (cur_sat > run_max) ? cur_sat : run_max;
`ifdef ERR_SUM_EN
      run_sum <= run_sum + {4'b0000, cur_sat};
`endif
    end
  end

  // Result registers: published in DECIDE, held in DONE, cleared by restart.
  always_ff @(posedge clk_conv) begin
    if (rst_conv) begin
      iter_cnt <= '0;
      max_err  <= '0;
      done_r   <= 1'b0;
      conv_r   <= 1'b0;
      next_r   <= 1'b0;
`ifdef ERR_SUM_EN
      err_sum  <= '0;
`endif
      for (int i = 0; i < 16; i++) w_out[i] <= '0;
    end else begin
      next_r <= 1'b0;
      case (state)
        S_DECIDE: begin
          max_err  <= run_max;
`ifdef ERR_SUM_EN
          err_sum  <= run_sum;
`endif
          // A restart landing on the decide cycle still wins for the count.
          iter_cnt <= bus.i_restart ? 8'd0 : cnt_inc;
          if (conv_hit || limit_hit) begin
            done_r <= 1'b1;
            conv_r <= conv_hit;
            for (int i = 0; i < 16; i++) w_out[i] <= cap_w[i];
          end else begin
            next_r <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.i_restart) begin
            iter_cnt <= '0;
            max_err  <= '0;
            done_r   <= 1'b0;
            conv_r   <= 1'b0;
`ifdef ERR_SUM_EN
            err_sum  <= '0;
`endif
          end
        end
        default: begin
          if (bus.i_restart) iter_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.ow          = w_out;
  assign bus.o_busy      = (state == S_SCAN) || (state == S_DECIDE);
  assign bus.o_next_iter = next_r;
  assign bus.o_done      = done_r;
  assign bus.o_converged = conv_r;
  assign bus.o_iter_cnt  = iter_cnt;
  assign bus.o_max_err   = max_err;
  assign bus.o_dbg_state = state;
`ifdef ERR_SUM_EN
  assign bus.o_err_sum   = err_sum;
`endif

endmodule

// File: tb/tb_error_conv_check.sv
// Bench for error_conv_check: directed scenarios with literal expectations,
// then randomized per-cycle stimulus, all checked every cycle against a
// pass-level behavioural model (capture -> 17 cycles -> result).
module tb_error_conv_check;
  localparam int            DW       = 26;
  localparam int            MAX_ITER = 4;
  localparam logic [DW-1:0] TOL      = 26'd8;
  localparam logic [DW-1:0] SAT      = 26'h1FFFFFF;
`ifdef ERR_SUM_EN
  localparam logic [DW+3:0] SUM_TOL  = 30'd64;
`endif

  // ---------------- clock / reset ----------------
  logic clk_conv = 1'b0;
  logic rst_conv = 1'b1;
  always #5 clk_conv = ~clk_conv;

  error_conv_check_if #(.DW(DW)) bus ();

  error_conv_check #(.DW(DW), .TOL(TOL), .MAX_ITER(MAX_ITER)) dut (
    .clk_conv (clk_conv),
    .rst_conv (rst_conv),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] exp_q [$];   // expected max per pending pass
`ifdef ERR_SUM_EN
  logic [DW+3:0] sum_q [$];
  logic [DW+3:0] m_sum;
`endif
  int            m_busy_left;
  logic          m_done, m_conv, m_next;
  logic [7:0]    m_cnt;
  logic [DW-1:0] m_max;
  logic [DW-1:0] m_w     [16];
  logic [DW-1:0] m_cap_w [16];

  function automatic logic [DW-1:0] sat(input logic [DW-1:0] e);
    return e[DW-1] ? SAT : e;
  endfunction

  task automatic model_reset();
    m_busy_left = 0;
    m_done = 0; m_conv = 0; m_next = 0; m_cnt = 0; m_max = 0;
`ifdef ERR_SUM_EN
    m_sum = 0; sum_q.delete();
`endif
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin m_w[i] = 0; m_cap_w[i] = 0; end
  endtask

  task automatic model_capture();
    logic [DW-1:0] mx;
    logic [DW+3:0] sm;
    mx = 0; sm = 0;
    for (int i = 0; i < 16; i++) begin
      if (sat(bus.i_err[i]) > mx) mx = sat(bus.i_err[i]);
      sm = sm + 30'(sat(bus.i_err[i]));
      m_cap_w[i] = bus.iw_new[i];
    end
    exp_q.push_back(mx);
`ifdef ERR_SUM_EN
    sum_q.push_back(sm);
`endif
    m_busy_left = 17;
  endtask

  task automatic model_finish();
    logic ok;
    logic [7:0] nc;
    m_max = exp_q.pop_front();
    ok = (m_max <= TOL);
`ifdef ERR_SUM_EN
    m_sum = sum_q.pop_front();
    ok = ok && (m_sum <= SUM_TOL);
`endif
    nc = m_cnt + 8'd1;
    m_cnt = nc;
    if (ok || nc == 8'(MAX_ITER)) begin
      m_done = 1; m_conv = ok;
      for (int i = 0; i < 16; i++) m_w[i] = m_cap_w[i];
    end else begin
      m_next = 1;
    end
  endtask

  // Model advances on every rising edge from the inputs the driver set.
  initial begin
    model_reset();
    forever begin
      @(posedge clk_conv);
      if (rst_conv) begin
        model_reset();
      end else begin
        m_next = 0;
        if (m_busy_left > 0) begin
          m_busy_left--;
          if (m_busy_left == 0) model_finish();
          else if (bus.i_restart) m_cnt = 0;
        end else if (m_done) begin
          if (bus.i_restart) begin
            m_done = 0; m_conv = 0; m_cnt = 0; m_max = 0;
`ifdef ERR_SUM_EN
            m_sum = 0;
`endif
          end
        end else begin
          if (bus.i_restart) m_cnt = 0;
          if (bus.en_conv) model_capture();
        end
      end
    end
  end

  // Compare process: every falling edge once out of the initial reset.
  initial begin
    forever begin
      @(negedge clk_conv);
      if (chk_en) begin
        check("o_busy", bus.o_busy, m_busy_left > 0);
        check("o_next_iter", bus.o_next_iter, m_next);
        check("o_done", bus.o_done, m_done);
        check("o_converged", bus.o_converged, m_conv);
        check("o_iter_cnt", bus.o_iter_cnt, m_cnt);
        check("o_max_err", bus.o_max_err, m_max);
`ifdef ERR_SUM_EN
        check("o_err_sum", bus.o_err_sum, m_sum);
`endif
        for (int i = 0; i < 16; i++) check($sformatf("ow[%0d]", i), bus.ow[i], m_w[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [DW-1:0] w_a [16];

  task automatic set_err_all(input logic [DW-1:0] v);
    for (int i = 0; i < 16; i++) bus.i_err[i] = v;
  endtask

  task automatic rand_w();
    for (int i = 0; i < 16; i++) bus.iw_new[i] = DW'($urandom);
  endtask

  task automatic pulse_en();
    bus.en_conv = 1'b1;
    @(negedge clk_conv);
    bus.en_conv = 1'b0;
  endtask

  task automatic pulse_restart();
    bus.i_restart = 1'b1;
    @(negedge clk_conv);
    bus.i_restart = 1'b0;
  endtask

  task automatic wait_result();
    int c = 0;
    while (!(bus.o_done || bus.o_next_iter) && c < 40) begin
      @(negedge clk_conv);
      c++;
    end
    check("result_seen", bus.o_done || bus.o_next_iter, 1'b1);
  endtask

  task automatic new_err_set();
    int mode;
    mode = $urandom_range(0, 3);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       bus.i_err[i] = DW'($urandom_range(0, 8));
        1:       bus.i_err[i] = DW'($urandom_range(0, 12));
        2:       bus.i_err[i] = DW'($urandom_range(6, 9));
        default: bus.i_err[i] = DW'($urandom_range(0, 8));
      endcase
    end
    if (mode == 3) bus.i_err[$urandom_range(0, 15)] = 26'h3FFFFFF - 26'($urandom_range(0, 1000));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc;
    bus.en_conv = 1'b0;
    bus.i_restart = 1'b0;
    set_err_all('0);
    for (int i = 0; i < 16; i++) bus.iw_new[i] = '0;
    rst_conv = 1'b1;
    repeat (3) @(posedge clk_conv);
    @(negedge clk_conv);
    rst_conv = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_cnt", bus.o_iter_cnt, 0);
    check("rst_ow0", bus.ow[0], 0);

    // All errors zero: converged after one pass, W published, 17 busy cycles.
    set_err_all('0);
    rand_w();
    for (int i = 0; i < 16; i++) w_a[i] = bus.iw_new[i];
    pulse_en();
    bc = 0;
    while (bus.o_busy && bc < 40) begin bc++; @(negedge clk_conv); end
    check("t1_busy_cycles", bc, 17);
    check("t1_done", bus.o_done, 1);
    check("t1_conv", bus.o_converged, 1);
    check("t1_cnt", bus.o_iter_cnt, 1);
    check("t1_max", bus.o_max_err, 0);
    for (int i = 0; i < 16; i++) check("t1_ow", bus.ow[i], w_a[i]);
    rand_w();
    pulse_restart();
    check("t1_restart_cnt", bus.o_iter_cnt, 0);
    check("t1_restart_done", bus.o_done, 0);
    check("t1_restart_ow_kept", bus.ow[3], w_a[3]);

    // Errors 3, i34=9 -> another iteration; then i34=8 (== TOL) -> converged.
    set_err_all(26'd3);
    bus.i_err[11] = 26'd9;
    pulse_en();
    wait_result();
    check("t2_next", bus.o_next_iter, 1);
    check("t2_max", bus.o_max_err, 9);
    check("t2_cnt", bus.o_iter_cnt, 1);
    check("t2_done", bus.o_done, 0);
    bus.i_err[11] = 26'd8;
    pulse_en();
    wait_result();
    check("t2b_conv", bus.o_converged, 1);
    check("t2b_done", bus.o_done, 1);
    check("t2b_cnt", bus.o_iter_cnt, 2);
    pulse_restart();

    // Constant error 100: limit reached on the 4th pass.
    set_err_all(26'd100);
    for (int p = 1; p <= 3; p++) begin
      pulse_en();
      wait_result();
      check("t3_next", bus.o_next_iter, 1);
      check("t3_cnt", bus.o_iter_cnt, 8'(p));
    end
    pulse_en();
    wait_result();
    check("t3_done", bus.o_done, 1);
    check("t3_conv", bus.o_converged, 0);
    check("t3_cnt4", bus.o_iter_cnt, 4);
    check("t3_max", bus.o_max_err, 100);
    pulse_restart();

    // i23 = -5 saturates; mid-scan input change and en pulse are ignored.
    set_err_all('0);
    bus.i_err[6] = 26'h3FFFFFB;
    pulse_en();
    repeat (4) @(negedge clk_conv);
    set_err_all('0);
    rand_w();
    pulse_en();
    wait_result();
    check("t4_next", bus.o_next_iter, 1);
    check("t4_max", bus.o_max_err, 26'h1FFFFFF);
    check("t4_conv", bus.o_converged, 0);
    check("t4_cnt", bus.o_iter_cnt, 1);

    // Captured W is what gets published, not the live inputs.
    set_err_all('0);
    rand_w();
    for (int i = 0; i < 16; i++) w_a[i] = bus.iw_new[i];
    pulse_en();
    repeat (3) @(negedge clk_conv);
    rand_w();
    set_err_all(26'd50);
    pulse_en();
    wait_result();
    check("t5_done", bus.o_done, 1);
    check("t5_conv", bus.o_converged, 1);
    check("t5_cnt", bus.o_iter_cnt, 2);
    for (int i = 0; i < 16; i++) check("t5_ow", bus.ow[i], w_a[i]);
    pulse_restart();

    // Reset in the middle of a scan (idx=7).
    set_err_all('0);
    pulse_en();
    repeat (7) @(negedge clk_conv);
    rst_conv = 1'b1;
    @(negedge clk_conv);
    rst_conv = 1'b0;
    check("t6_busy", bus.o_busy, 0);
    check("t6_done", bus.o_done, 0);
    check("t6_next", bus.o_next_iter, 0);
    check("t6_cnt", bus.o_iter_cnt, 0);
    check("t6_max", bus.o_max_err, 0);
    for (int i = 0; i < 16; i++) check("t6_ow", bus.ow[i], 0);

`ifdef ERR_SUM_EN
    // Sum gate: 16*5=80 > 64 fails, 16*4=64 passes.
    set_err_all(26'd5);
    pulse_en();
    wait_result();
    check("ts_next", bus.o_next_iter, 1);
    check("ts_sum80", bus.o_err_sum, 80);
    set_err_all(26'd4);
    pulse_en();
    wait_result();
    check("ts_conv", bus.o_converged, 1);
    check("ts_sum64", bus.o_err_sum, 64);
`endif

    // In DONE, restart together with en: restart wins, no capture.
    set_err_all('0);
    pulse_en();
    wait_result();
    check("t7_done", bus.o_done, 1);
    set_err_all(26'd200);
    bus.i_restart = 1'b1;
    bus.en_conv = 1'b1;
    @(negedge clk_conv);
    bus.i_restart = 1'b0;
    bus.en_conv = 1'b0;
    check("t7_cnt", bus.o_iter_cnt, 0);
    check("t7_done_clr", bus.o_done, 0);
    check("t7_busy", bus.o_busy, 0);
    @(negedge clk_conv);
    check("t7_no_capture", bus.o_busy, 0);

    // Randomized phase: per-cycle random controls and data.
    new_err_set();
    for (int c = 0; c < 2500; c++) begin
      rst_conv = ($urandom_range(0, 999) == 0);
      bus.en_conv = ($urandom_range(0, 3) == 0);
      if (m_busy_left == 1) bus.i_restart = 1'b0;
      else if (m_done) bus.i_restart = ($urandom_range(0, 5) == 0);
      else bus.i_restart = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) new_err_set();
      rand_w();
      @(negedge clk_conv);
    end
    rst_conv = 1'b0;
    bus.en_conv = 1'b0;
    bus.i_restart = 1'b0;
    repeat (20) @(negedge clk_conv);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/error_conv_check.md
Name: error_conv_check

Overview:
- Stage directly downstream of the absolute-error/W delivery stage in the FastICA iteration loop.
- Captures the 16 per-element absolute errors (Q13 fixed point, 26-bit signed) and the matching 16 candidate W_new values.
- Serially scans the errors for the maximum and compares it with a tolerance.
- Then either requests another iteration, or declares convergence or iteration-limit exhaustion and publishes the final W.

Parameters:
- DW, 26, data width of every error/weight word (Q13).
- TOL, 26'd8, convergence tolerance on max |error| (8/8192 ≈ 1e-3).
- MAX_ITER, 64, iteration limit (1..255).

Ports:
- clk_conv  input  1  clock, rising edge
- rst_conv  input  1  reset, synchronous, active-high
- en_conv  input  1  start pulse; sampled only in IDLE
- i_restart  input  1  clear iteration count and leave DONE
- i11..i14, i21..i24, i31..i34, i41..i44  input  DW each  absolute errors from the upstream stage
- iw_new11..iw_new44 (16 ports)  input  DW each  candidate W matching the errors
- ow11..ow44 (16 ports)  output  DW each  final W, valid while o_done=1
- o_busy  output  1  high in SCAN and DECIDE
- o_next_iter  output  1  one-cycle pulse requesting another iteration
- o_done  output  1  level; high in DONE
- o_converged  output  1  level; qualifies o_done
- o_iter_cnt  output  8  completed iterations
- o_max_err  output  DW  max error of the last scan

Behaviour:
- Reset (rst_conv=1 at an edge):
  - State goes to IDLE; all outputs are 0, including ow*.
  - Internal capture registers and the scan index go to 0.
  - Reset overrides every other input in any state, including mid-SCAN.
- States: IDLE, SCAN, DECIDE, DONE.
- IDLE:
  - On an edge with en_conv=1, latch all 16 errors and 16 iw_new into capture registers.
  - Set running max=0 and idx=0, then go to SCAN.
  - en_conv=0 keeps the block in IDLE.
- SCAN:
  - One element per cycle, row-major order: idx 0→i11 … idx 15→i44.
  - max <= (e > max) ? e : max.
  - A negative captured error (upstream overflow) is treated as 26'h1FFFFFF (saturated positive), which forces non-convergence.
  - idx=15 → DECIDE.
  - en_conv is ignored while busy; the capture registers are not disturbed.
- DECIDE (single cycle):
  - o_max_err <= max; o_iter_cnt <= o_iter_cnt+1.
  - If max <= TOL: o_converged<=1, o_done<=1, ow* <= captured W, go to DONE.
  - Else if o_iter_cnt+1 == MAX_ITER: o_converged<=0, o_done<=1, ow* <= captured W, go to DONE.
  - Else: o_next_iter<=1 for exactly one cycle, go to IDLE.
- Latency: with en_conv sampled at edge T, o_next_iter or o_done is high in the cycle following edge T+17. o_busy is high for cycles T+1..T+17 (17 cycles).
- DONE:
  - Outputs are held; en_conv is ignored.
  - i_restart=1 clears o_iter_cnt, o_done, o_converged and o_max_err, and returns to IDLE. ow* keeps its last value.
- i_restart outside DONE: clears o_iter_cnt only; the state is unaffected.
- Simultaneous i_restart and en_conv in DONE: restart wins and en_conv is dropped.
- Comparison with TOL is inclusive: max == TOL counts as converged.
- o_iter_cnt never wraps, because MAX_ITER ≤ 255.

Optional Feature:
- Macro: ERR_SUM_EN.
- With the macro defined:
  - An extra output o_err_sum [DW+3:0] and an extra parameter SUM_TOL (default 30'd64) are present.
  - SCAN also accumulates the sum of the 16 errors (negatives saturated as above). The sum is cleared on capture and published in DECIDE.
  - Convergence requires max <= TOL AND sum <= SUM_TOL.
- Without the macro: no port, no accumulator; convergence uses max only.

Test Plan:
- Reset, then all errors=0, en_conv pulse at edge T → o_done=1, o_converged=1, o_iter_cnt=1, o_max_err=0, o_busy high for 17 cycles, ow* equals the iw_new* sampled at T.
- Errors all 3 except i34=9 → o_next_iter one-cycle pulse after T+17, o_max_err=9, o_iter_cnt=1, back to IDLE, o_done=0. Repeat with i34=8 → converged, o_iter_cnt=2.
- Build with MAX_ITER=4 and errors constant 100 → three o_next_iter pulses, then the 4th pass gives o_done=1, o_converged=0, o_iter_cnt=4.
- i23=-5 with all others 0 → o_max_err=26'h1FFFFFF, no convergence. Change iw_new*/errors mid-SCAN and pulse en_conv → result uses the captured values only.
- Assert rst_conv at SCAN idx=7 → next cycle IDLE, all outputs 0. In DONE, assert i_restart and en_conv together → IDLE, o_iter_cnt=0, no new capture.
- ERR_SUM_EN build, every error=5 (max≤TOL, sum=80>64) → not converged, o_err_sum=80. Every error=4 → converged, o_err_sum=64.
